// File: rtl/uart_rx.sv
// UART receiver for 8N1-style frames. It uses the baud generator's 16x tick for mid-bit sampling.
// Each frame produces a one-cycle done strobe, a data byte and a framing-error flag.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [4:0]    S_MID  = 5'(OVS / 2 - 1);
    localparam logic [4:0]    S_BIT  = 5'(OVS - 1);
    localparam logic [4:0]    S_STOP = 5'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [DBIT-1:0] dout_reg, dout_next;
    logic            ferr_reg, ferr_next;
    logic            done_reg, done_next;
    logic            armed_reg, armed_next;
    logic            rx_meta_reg, rx_s_reg;

    // Two-flop synchronizer. Both flops reset to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            ferr_reg  <= 1'b0;
            done_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            ferr_reg  <= ferr_next;
            done_reg  <= done_next;
            armed_reg <= armed_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout_reg;
        ferr_next  = ferr_reg;
        done_next  = 1'b0;
        armed_next = armed_reg;

        case (state_reg)
            IDLE: begin
                // The armed flag stops a held-low line (break) from restarting frames.
                if (!rx_s_reg && armed_reg) begin
                    state_next = START;
                    s_next     = '0;
                    armed_next = 1'b0;
                end else if (rx_s_reg) begin
                    armed_next = 1'b1;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_MID) begin
                        if (!rx_s_reg) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        b_next = {rx_s_reg, b_reg[DBIT-1:1]};
                        s_next = '0;
                        if (n_reg == N_LAST) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_STOP) begin
                        state_next = IDLE;
                        dout_next  = b_reg;
                        ferr_next  = ~rx_s_reg;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dout         = dout_reg;
    assign frame_err    = ferr_reg;
    assign rx_done_tick = done_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. A scoreboard queue holds the expected byte and error flag for each frame.
// Each rx_done_tick pops one entry and is checked against it.
module tb_uart_rx;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    logic [1:0] tcnt = 2'd0;
    logic       tick_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [8:0] exp_q[$];

    uart_rx #(.DBIT(8), .SB_TICK(16), .OVS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tcnt <= tcnt + 2'd1;
    assign s_tick = tick_en && (tcnt == 2'd3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: each done pulse pops one expected {frame_err, byte}.
    always @(negedge clk) begin
        if (rx_done_tick) begin
            logic [8:0] e;
            done_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_done: observed dout %0h with empty queue", dout);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                $display("done: dout=%02h frame_err=%0b expected %02h/%0b", dout, frame_err, e[7:0], e[8]);
                chk("done_dout", 32'(dout), 32'(e[7:0]));
                chk("done_ferr", 32'(frame_err), 32'(e[8]));
            end
        end
    end

    task automatic hold_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends frame bits [0..nbits-1], LSB first; frame = {stop, data, start}.
    task automatic send_bits(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx = frame[i];
            hold_clk(BIT_CLK);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_val);
        exp_q.push_back({~stop_val, data});
        send_bits({stop_val, data, 1'b0}, 10);
    endtask

    initial begin
        int base;
        hold_clk(3);
        chk("reset_dout", 32'(dout), 32'h0);
        chk("reset_done", 32'(rx_done_tick), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        hold_clk(BIT_CLK);

        // Basic frame
        base = done_cnt;
        send_frame(8'h55, 1'b1);
        chk("f55_count", 32'(done_cnt - base), 32'd1);
        chk("f55_dout", 32'(dout), 32'h55);
        chk("f55_busy", 32'(busy), 32'h0);
        hold_clk(BIT_CLK);

        // Back-to-back frames
        base = done_cnt;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        chk("b2b_count", 32'(done_cnt - base), 32'd2);
        chk("b2b_queue", 32'(exp_q.size()), 32'd0);
        hold_clk(BIT_CLK);

        // Short glitch is rejected
        base = done_cnt;
        rx = 1'b0;
        hold_clk(20);
        rx = 1'b1;
        hold_clk(4 * BIT_CLK);
        chk("glitch_count", 32'(done_cnt - base), 32'd0);
        chk("glitch_dout", 32'(dout), 32'h0F);
        chk("glitch_busy", 32'(busy), 32'h0);

        // Framing error followed by a break
        base = done_cnt;
        send_frame(8'hFF, 1'b0);
        hold_clk(2000);
        chk("break_count", 32'(done_cnt - base), 32'd1);
        chk("break_dout", 32'(dout), 32'hFF);
        chk("break_ferr", 32'(frame_err), 32'h1);
        chk("break_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        hold_clk(2 * BIT_CLK);
        chk("break_end_count", 32'(done_cnt - base), 32'd1);

        // Reset during bit 4 of 0x3C
        base = done_cnt;
        send_bits({1'b1, 8'h3C, 1'b0}, 5);
        hold_clk(BIT_CLK / 2);
        chk("mid_busy", 32'(busy), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(rx_done_tick), 32'h0);
        rx = 1'b1;
        hold_clk(4);
        reset = 1'b1;
        hold_clk(BIT_CLK);
        send_frame(8'h81, 1'b1);
        chk("post_rst_count", 32'(done_cnt - base), 32'd1);
        chk("post_rst_dout", 32'(dout), 32'h81);
        hold_clk(BIT_CLK);

        // Ticks frozen for 500 clk mid-DATA
        base = done_cnt;
        exp_q.push_back({1'b0, 8'hB6});
        send_bits({1'b1, 8'hB6, 1'b0}, 4);
        rx = 1'b0;
        hold_clk(BIT_CLK / 2);
        tick_en = 1'b0;
        hold_clk(500);
        chk("freeze_busy", 32'(busy), 32'h1);
        chk("freeze_count", 32'(done_cnt - base), 32'd0);
        tick_en = 1'b1;
        hold_clk(BIT_CLK / 2);
        send_bits({1'b1, 8'hB6, 1'b0} >> 5, 5);
        chk("freeze_done_count", 32'(done_cnt - base), 32'd1);
        chk("freeze_dout", 32'(dout), 32'hB6);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        hold_clk(BIT_CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
